// File: rtl/id_token_ctrl.sv
// rtl/id_token_ctrl.sv - identifier recognizer that packs each identifier into a token record
module id_token_ctrl #(
   parameter int POS_W = 8,
   parameter int LEN_W = 6,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [7:0]       in_char,
   input  logic             in_last,
   output logic             tok_valid,
   input  logic             tok_ready,
   output logic [POS_W-1:0] tok_start,
   output logic [LEN_W-1:0] tok_len,
   output logic             tok_digit,
   output logic             tok_trunc,
   output logic [CNT_W-1:0] id_count
);

   typedef enum logic {IDLE, IN_ID} state_t;

   localparam logic [LEN_W-1:0] LEN_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

   state_t           state;
   logic [POS_W-1:0] pos;
   logic [POS_W-1:0] start_r;
   logic [LEN_W-1:0] len_r;
   logic             dig_r;
   logic             trunc_r;

   logic             is_l;
   logic             is_d;
   logic             accept;
   logic             xfer;
   logic             len_sat;
   logic [LEN_W-1:0] len_nxt;
   logic             dig_nxt;
   logic             trunc_nxt;

   assign is_l      = (in_char >= 8'd65 && in_char <= 8'd90) ||
                      (in_char >= 8'd97 && in_char <= 8'd122);
   assign is_d      = (in_char >= 8'd48 && in_char <= 8'd57);
   assign in_ready  = !tok_valid || tok_ready;
   assign accept    = in_valid && in_ready;
   assign xfer      = tok_valid && tok_ready;
   assign len_sat   = (len_r == LEN_MAX);
   assign len_nxt   = len_sat ? len_r : len_r + LEN_ONE;
   assign dig_nxt   = dig_r | is_d;
   assign trunc_nxt = trunc_r | len_sat;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         pos       <= '0;
         start_r   <= '0;
         len_r     <= '0;
         dig_r     <= 1'b0;
         trunc_r   <= 1'b0;
         tok_valid <= 1'b0;
         tok_start <= '0;
         tok_len   <= '0;
         tok_digit <= 1'b0;
         tok_trunc <= 1'b0;
         id_count  <= '0;
      end else begin
         if (xfer) begin
            tok_valid <= 1'b0;
            if (id_count != CNT_MAX)
               id_count <= id_count + 1'b1;
         end
         // An emit below overrides the clear above, giving back-to-back tokens.
         if (accept) begin
            pos <= in_last ? '0 : pos + 1'b1;
            case (state)
               IDLE: begin
                  if (is_l) begin
                     if (in_last) begin
                        tok_valid <= 1'b1;
                        tok_start <= pos;
                        tok_len   <= LEN_ONE;
                        tok_digit <= 1'b0;
                        tok_trunc <= 1'b0;
                     end else begin
                        state   <= IN_ID;
                        start_r <= pos;
                        len_r   <= LEN_ONE;
                        dig_r   <= 1'b0;
                        trunc_r <= 1'b0;
                     end
                  end
               end
               IN_ID: begin
                  if (is_l || is_d) begin
                     if (in_last) begin
                        state     <= IDLE;
                        tok_valid <= 1'b1;
                        tok_start <= start_r;
                        tok_len   <= len_nxt;
                        tok_digit <= dig_nxt;
                        tok_trunc <= trunc_nxt;
                     end else begin
                        len_r   <= len_nxt;
                        dig_r   <= dig_nxt;
                        trunc_r <= trunc_nxt;
                     end
                  end else begin
                     state     <= IDLE;
                     tok_valid <= 1'b1;
                     tok_start <= start_r;
                     tok_len   <= len_r;
                     tok_digit <= dig_r;
                     tok_trunc <= trunc_r;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule
